microseq: RTL and testbench

- Microprogram sequencer for the 512x16 microcode ROM (9-bit address, 16-bit word, combinational read).
- Holds the micro-PC and drives the ROM address. Decodes each fetched word's sequencing field. Supports branch, call/return, dispatch and wait.
- Hands the control field, registered, to the PDP-11 datapath.
- Sits between the instruction decoder (start/dispatch) and the datapath (uword/conditions).

---
 rtl/microseq.sv | 198 +++++++++++++++++++
 tb/tb_microseq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : microseq                                                    |
// | Purpose  : Microprogram sequencer for a 512x16 microcode ROM; optional |
// |            single-step control enabled by MICROSEQ_SINGLE_STEP_EN.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module microseq #(
    parameter logic [8:0] START_ADDR  = 9'h000,
    parameter int         STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  disp_in,
    input  logic [15:0] cond_in,
    output logic [8:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [12:0] uword,
    output logic        uword_valid,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef MICROSEQ_SINGLE_STEP_EN
    ,
    input  logic        step_mode,
    input  logic        step
`endif
);

    localparam int c_SPW   = $clog2(STACK_DEPTH + 1);
    localparam int c_IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int c_NSLOT = 1 << c_IW;
    localparam logic [c_SPW-1:0] c_SP_FULL = c_SPW'(STACK_DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_ERR  = 2'd2;

    localparam logic [2:0] c_OP_NEXT = 3'd0;
    localparam logic [2:0] c_OP_JMP  = 3'd1;
    localparam logic [2:0] c_OP_JCC  = 3'd2;
    localparam logic [2:0] c_OP_CALL = 3'd3;
    localparam logic [2:0] c_OP_RET  = 3'd4;
    localparam logic [2:0] c_OP_DISP = 3'd5;
    localparam logic [2:0] c_OP_WAIT = 3'd6;

    logic [1:0]       r_state;
    logic [8:0]       r_upc;
    logic [c_SPW-1:0] r_sp;
    logic [8:0]       r_stack [c_NSLOT];
    logic [12:0]      r_uword;
    logic             r_valid;
    logic             r_done;
    logic             r_error;

    logic [1:0]       w_state_nxt;
    logic [8:0]       w_upc_nxt;
    logic [c_SPW-1:0] w_sp_nxt;
    logic             w_push;
    logic             w_valid_nxt;
    logic             w_done_nxt;
    logic             w_error_nxt;
    logic             w_uword_ld;
    logic             w_fault;
    logic             w_adv;
    logic [2:0]       w_op;
    logic [8:0]       w_target;
    logic             w_cond;
    logic [8:0]       w_upc_inc;
    logic [c_IW-1:0]  w_push_idx;
    logic [c_IW-1:0]  w_pop_idx;

`ifdef MICROSEQ_SINGLE_STEP_EN
    assign w_adv = !step_mode || step;
`else
    assign w_adv = 1'b1;
`endif

    assign w_op       = rom_data[15:13];
    assign w_target   = rom_data[8:0];
    assign w_cond     = cond_in[rom_data[12:9]];
    assign w_upc_inc  = r_upc + 9'd1;
    assign w_push_idx = c_IW'(r_sp);
    assign w_pop_idx  = c_IW'(r_sp - 1'b1);

    assign rom_addr    = r_upc;
    assign uword       = r_uword;
    assign uword_valid = r_valid;
    assign busy        = (r_state == c_ST_RUN);
    assign done        = r_done;
    assign error       = r_error;

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_sp_nxt    = r_sp;
        w_push      = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_error_nxt = r_error;
        w_uword_ld  = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_adv) begin
                    w_uword_ld  = 1'b1;
                    w_valid_nxt = 1'b1;
                    case (w_op)
                        c_OP_NEXT: w_upc_nxt = w_upc_inc;
                        c_OP_JMP:  w_upc_nxt = w_target;
                        c_OP_JCC:  w_upc_nxt = w_cond ? w_target : w_upc_inc;
                        c_OP_CALL: begin
                            if (r_sp == c_SP_FULL) begin
                                w_fault = 1'b1;
                            end else begin
                                w_push    = 1'b1;
                                w_sp_nxt  = r_sp + 1'b1;
                                w_upc_nxt = w_target;
                            end
                        end
                        c_OP_RET: begin
                            if (r_sp == '0) begin
                                w_fault = 1'b1;
                            end else begin
                                w_sp_nxt  = r_sp - 1'b1;
                                w_upc_nxt = r_stack[w_pop_idx];
                            end
                        end
                        c_OP_DISP: w_upc_nxt = {1'b1, disp_in};
                        c_OP_WAIT: begin
                            if (w_cond) begin
                                w_upc_nxt = w_upc_inc;
                            end else begin
                                w_valid_nxt = 1'b0;
                            end
                        end
                        default: begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = c_ST_IDLE;
                            w_upc_nxt   = START_ADDR;
                        end
                    endcase
                    // A faulting CALL/RET leaves upc and the stack untouched
                    if (w_fault) begin
                        w_valid_nxt = 1'b0;
                        w_error_nxt = 1'b1;
                        w_state_nxt = c_ST_ERR;
                    end
                end
            end
            c_ST_IDLE, c_ST_ERR: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                    w_upc_nxt   = START_ADDR;
                    w_sp_nxt    = '0;
                    w_error_nxt = 1'b0;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_upc   <= START_ADDR;
            r_sp    <= '0;
            r_uword <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_sp    <= w_sp_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
            if (w_uword_ld) begin
                r_uword <= rom_data[12:0];
            end
        end
    end

    // Stack contents survive HALT; only the pointer is rewound on start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NSLOT; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[w_push_idx] <= w_upc_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_microseq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_microseq                                                 |
// | Purpose  : Self-checking bench for microseq with a queue-based model.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_microseq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  disp_in = '0;
    logic [15:0] cond_in = '0;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [12:0] uword;
    logic        uword_valid, busy, done, error;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;

    logic [15:0] rom [512];
    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: program counter, queue as return stack
    int          m_state;
    logic [8:0]  m_pc;
    logic [8:0]  m_stk [$];
    logic        m_valid, m_done, m_err;
    logic [12:0] m_uword;

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    microseq #(.START_ADDR(9'h000), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .disp_in(disp_in),
        .cond_in(cond_in), .rom_addr(rom_addr), .rom_data(rom_data),
        .uword(uword), .uword_valid(uword_valid), .busy(busy), .done(done),
        .error(error)
`ifdef MICROSEQ_SINGLE_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    task automatic rom_fill(input logic [15:0] w);
        for (int i = 0; i < 512; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        start = 0; cond_in = '0; disp_in = '0; step_mode = 0; step = 0;
        reset_n = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        rom_fill(16'hE000);
    endtask

    task automatic go();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 9'h000; m_stk.delete();
        m_valid = 0; m_done = 0; m_err = 0; m_uword = '0;
    endtask

    task automatic model_tick();
        logic [15:0] w;
        logic [8:0]  inc;
        logic        adv, fault;
        w = rom[m_pc];
        inc = m_pc + 9'd1;
        fault = 0;
        m_valid = 0; m_done = 0;
`ifdef MICROSEQ_SINGLE_STEP_EN
        adv = !step_mode || step;
`else
        adv = 1;
`endif
        if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_pc = 9'h000; m_stk.delete(); m_err = 0;
            end
        end else if (adv) begin
            m_uword = w[12:0];
            m_valid = 1;
            case (w[15:13])
                3'd0: m_pc = inc;
                3'd1: m_pc = w[8:0];
                3'd2: m_pc = cond_in[w[12:9]] ? w[8:0] : inc;
                3'd3: if (m_stk.size() == DEPTH) fault = 1;
                      else begin m_stk.push_back(inc); m_pc = w[8:0]; end
                3'd4: if (m_stk.size() == 0) fault = 1;
                      else m_pc = m_stk.pop_back();
                3'd5: m_pc = {1'b1, disp_in};
                3'd6: if (cond_in[w[12:9]]) m_pc = inc; else m_valid = 0;
                default: begin m_done = 1; m_state = 0; m_pc = 9'h000; end
            endcase
            if (fault) begin m_valid = 0; m_err = 1; m_state = 2; end
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        #1;
        n_tests++;
        if (rom_addr !== 9'h000 || uword !== 13'h0 || uword_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: addr=%h uword=%h valid=%b busy=%b done=%b err=%b, want all zero",
                     rom_addr, uword, uword_valid, busy, done, error);
        end
    endtask

    task automatic test_sequence();
        int nvalid;
        do_reset();
        for (int i = 0; i < 3; i++) rom[i] = 16'h0000;
        rom[3] = 16'hE000;
        go();
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rom_addr !== 9'(i) || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_step%0d: addr=%h busy=%b done=%b, want addr=%h busy=1 done=0",
                         i, rom_addr, busy, done, 9'(i));
            end
            @(negedge clk);
            if (uword_valid === 1'b1) nvalid++;
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_done: done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || uword_valid !== 1'b0 || rom_addr !== 9'h000) begin
            n_fail++;
            $display("FAIL seq_after: done=%b valid=%b addr=%h, want 0 0 000", done, uword_valid, rom_addr);
        end
        n_tests++;
        if (nvalid != 4) begin
            n_fail++;
            $display("FAIL seq_valid_count: got %0d, want 4", nvalid);
        end
    endtask

    task automatic test_jcc(input logic c, input logic [8:0] exp_addr);
        do_reset();
        rom[0] = 16'h4409;
        cond_in = c ? 16'h0004 : 16'hFFFB;
        go();
        n_tests++;
        if (rom_addr !== 9'h000) begin
            n_fail++;
            $display("FAIL jcc_first: addr=%h, want 000", rom_addr);
        end
        @(negedge clk);
        n_tests++;
        if (rom_addr !== exp_addr || uword_valid !== 1'b1 || uword !== 13'h0409) begin
            n_fail++;
            $display("FAIL jcc_branch(c=%b): addr=%h valid=%b uword=%h, want addr=%h valid=1 uword=0409",
                     c, rom_addr, uword_valid, uword, exp_addr);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL jcc_halt: done=%b, want 1", done);
        end
    endtask

    task automatic test_call_ret();
        logic [8:0] exp_seq [3];
        exp_seq = '{9'h000, 9'h020, 9'h001};
        do_reset();
        rom[0] = 16'h6020; rom[9'h020] = 16'h8000; rom[1] = 16'hE000;
        go();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rom_addr !== exp_seq[i] || error !== 1'b0) begin
                n_fail++;
                $display("FAIL call_ret%0d: addr=%h err=%b, want addr=%h err=0", i, rom_addr, error, exp_seq[i]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL call_ret_done: done=%b err=%b, want 1 0", done, error);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        rom[0] = 16'h6000;
        go();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_tests++;
            if (rom_addr !== 9'h000 || uword_valid !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_call%0d: addr=%h valid=%b err=%b busy=%b, want 000 1 0 1",
                         i, rom_addr, uword_valid, error, busy);
            end
        end
        @(negedge clk);
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0 || uword_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fault: err=%b busy=%b valid=%b, want 1 0 0", error, busy, uword_valid);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: err=%b busy=%b, want 1 0", error, busy);
        end
        rom[0] = 16'hE000;
        go();
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b1 || rom_addr !== 9'h000) begin
            n_fail++;
            $display("FAIL ovf_restart: err=%b busy=%b addr=%h, want 0 1 000", error, busy, rom_addr);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_restart_halt: done=%b, want 1", done);
        end
    endtask

    task automatic test_dispatch_wait();
        do_reset();
        rom[0] = 16'hA000; rom[9'h135] = 16'hC600; rom[9'h136] = 16'hE000;
        disp_in = 8'h35;
        cond_in = 16'hFFF7;
        go();
        @(negedge clk);
        n_tests++;
        if (rom_addr !== 9'h135 || uword_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dispatch: addr=%h valid=%b, want 135 1", rom_addr, uword_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (rom_addr !== 9'h135 || uword_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_hold%0d: addr=%h valid=%b busy=%b, want 135 0 1",
                         i, rom_addr, uword_valid, busy);
            end
        end
        cond_in = 16'h0008;
        @(negedge clk);
        n_tests++;
        if (rom_addr !== 9'h136 || uword_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_release: addr=%h valid=%b, want 136 1", rom_addr, uword_valid);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_halt: done=%b, want 1", done);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        rom_fill(16'h0123);
        go();
        repeat (5) @(negedge clk);
        n_tests++;
        if (rom_addr !== 9'h005 || uword !== 13'h0123 || uword_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre: addr=%h uword=%h valid=%b, want 005 0123 1", rom_addr, uword, uword_valid);
        end
        #2 reset_n = 0;
        #1;
        n_tests++;
        if (rom_addr !== 9'h000 || uword !== 13'h0 || uword_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: addr=%h uword=%h valid=%b busy=%b done=%b err=%b, want all zero",
                     rom_addr, uword, uword_valid, busy, done, error);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || rom_addr !== 9'h000) begin
            n_fail++;
            $display("FAIL midrun_hold: done=%b addr=%h, want 0 000", done, rom_addr);
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || rom_addr !== 9'h000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle: busy=%b addr=%h done=%b, want 0 000 0", busy, rom_addr, done);
        end
    endtask

`ifdef MICROSEQ_SINGLE_STEP_EN
    task automatic test_step();
        logic [8:0] exp_addr;
        logic       s;
        do_reset();
        rom_fill(16'h0001);
        step_mode = 1; step = 0;
        go();
        exp_addr = 9'h000;
        for (int k = 0; k < 9; k++) begin
            s = (k % 3 == 1);
            step = s;
            @(negedge clk);
            step = 0;
            if (s) exp_addr = exp_addr + 9'd1;
            n_tests++;
            if (rom_addr !== exp_addr || uword_valid !== s || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL step%0d: addr=%h valid=%b busy=%b, want addr=%h valid=%b busy=1",
                         k, rom_addr, uword_valid, busy, exp_addr, s);
            end
        end
        n_tests++;
        if (rom_addr !== 9'h003) begin
            n_fail++;
            $display("FAIL step_total: addr=%h, want 003", rom_addr);
        end
        step_mode = 0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            start   = ($urandom_range(0, 7) == 0);
            cond_in = 16'($urandom);
            disp_in = 8'($urandom);
            step    = 1'($urandom);
`ifdef MICROSEQ_SINGLE_STEP_EN
            step_mode = (cyc >= 300);
`endif
            model_tick();
            @(negedge clk);
            n_tests++;
            if (rom_addr !== m_pc || uword_valid !== m_valid || done !== m_done ||
                error !== m_err || busy !== (m_state == 1) || uword !== m_uword) begin
                n_fail++;
                $display("FAIL random cyc%0d: addr=%h valid=%b done=%b err=%b busy=%b uword=%h, want %h %b %b %b %b %h",
                         cyc, rom_addr, uword_valid, done, error, busy, uword,
                         m_pc, m_valid, m_done, m_err, (m_state == 1), m_uword);
            end
        end
        start = 0;
    endtask

    initial begin
        rom_fill(16'hE000);
        test_reset();
        test_sequence();
        test_jcc(1'b1, 9'h009);
        test_jcc(1'b0, 9'h001);
        test_call_ret();
        test_overflow();
        test_dispatch_wait();
        test_reset_midrun();
`ifdef MICROSEQ_SINGLE_STEP_EN
        test_step();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
